// File: rtl/cmd_decod_seq.sv
`default_nettype none
// ============================================================================
// cmd_decod_seq : FIFO-buffered playback of encoded 32-bit memory command words
// Revision      : 1.0
// ============================================================================
module cmd_decod_seq #(
  parameter int ADDRESS_NUMBER  = 15,
  parameter int CMD_PAUSE_BITS  = 10,
  parameter int CMD_DONE_BIT    = 10,
  parameter int FIFO_DEPTH_BITS = 7
) (
  input  logic                      clk,
  input  logic                      mrst_n,
  input  logic [31:0]               enc_cmd,
  input  logic                      enc_wr,
  input  logic                      enc_done,
  input  logic                      clr_err,
  output logic [ADDRESS_NUMBER-1:0] phy_addr,
  output logic [2:0]                phy_bank,
  output logic [2:0]                phy_rcw,
  output logic                      phy_odt_en,
  output logic                      phy_cke,
  output logic                      phy_sel,
  output logic                      phy_dq_en,
  output logic                      phy_dqs_en,
  output logic                      phy_dqs_toggle,
  output logic                      phy_dci,
  output logic                      buf_wr,
  output logic                      buf_rd,
  output logic                      buf_rst,
  output logic                      seq_busy,
  output logic                      seq_done,
  output logic                      underrun,
  output logic                      overflow
);

  localparam int PTR_W = FIFO_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [31:0]               mem_q [DEPTH];
  logic [ADDRESS_NUMBER-1:0] addr_q, addr_d;
  logic [2:0]                bank_q, bank_d;
  logic [2:0]                rcw_q, rcw_d;
  logic [6:0]                flags_q, flags_d;
  logic [2:0]                strb_q, strb_d;
  logic [CMD_PAUSE_BITS-1:0] cnt_q, cnt_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      underrun_q, underrun_d;
  logic                      overflow_q, overflow_d;

  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      rd_en;
  logic                      wr_accept;
  logic                      underrun_evt;
  logic [31:0]               head;
  logic [ADDRESS_NUMBER-1:0] head_addr;
  logic                      head_pause;
  logic                      head_done;
  logic [CMD_PAUSE_BITS-1:0] head_ext;
  logic                      unused_enc_done;

  assign unused_enc_done = enc_done;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

  assign head       = mem_q[rd_ptr_q[PTR_W-2:0]];
  assign head_addr  = head[17 +: ADDRESS_NUMBER];
  assign head_pause = (head[13:11] == 3'b000);
  assign head_done  = head_pause & head_addr[CMD_DONE_BIT];
  assign head_ext   = head_pause ? head_addr[CMD_PAUSE_BITS-1:0]
                                 : CMD_PAUSE_BITS'(head[1]);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bank_d       = bank_q;
    rcw_d        = rcw_q;
    flags_d      = flags_q;
    strb_d       = strb_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_en        = 1'b0;
    underrun_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fifo_empty) begin
          // Starved: emit a NOP cycle with the previous word's levels held.
          rcw_d        = 3'b000;
          strb_d       = 3'b000;
          underrun_evt = 1'b1;
        end else begin
          rd_en   = 1'b1;
          busy_d  = 1'b1;
          addr_d  = head_addr;
          bank_d  = head[16:14];
          rcw_d   = head[13:11];
          flags_d = head[10:4];
          strb_d  = {head[3], head[2], head[0]};
          last_d  = head_done;
          if (head_ext != '0) begin
            cnt_d   = head_ext - CMD_PAUSE_BITS'(1);
            state_d = ST_HOLD;
          end else if (head_done) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_HOLD: begin
        rcw_d  = 3'b000;
        strb_d = 3'b000;
        if (cnt_q == '0) begin
          state_d = last_q ? ST_FINISH : ST_FETCH;
        end else begin
          cnt_d = cnt_q - CMD_PAUSE_BITS'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        addr_d  = '0;
        bank_d  = 3'b000;
        rcw_d   = 3'b000;
        flags_d = 7'b0000000;
        strb_d  = 3'b000;
        last_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a write into a full FIFO is kept.
    wr_accept  = enc_wr & (~fifo_full | rd_en);
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_accept);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
    underrun_d = (underrun_q & ~clr_err) | underrun_evt;
    overflow_d = (overflow_q & ~clr_err) | (enc_wr & ~wr_accept);
  end

  always_ff @(posedge clk) begin
    if (!mrst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      bank_q     <= 3'b000;
      rcw_q      <= 3'b000;
      flags_q    <= 7'b0000000;
      strb_q     <= 3'b000;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      rcw_q      <= rcw_d;
      flags_q    <= flags_d;
      strb_q     <= strb_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q[PTR_W-2:0]] <= enc_cmd;
  end

  assign phy_addr       = addr_q;
  assign phy_bank       = bank_q;
  assign phy_rcw        = rcw_q;
  assign phy_odt_en     = flags_q[6];
  assign phy_cke        = flags_q[5];
  assign phy_sel        = flags_q[4];
  assign phy_dq_en      = flags_q[3];
  assign phy_dqs_en     = flags_q[2];
  assign phy_dqs_toggle = flags_q[1];
  assign phy_dci        = flags_q[0];
  assign buf_wr         = strb_q[2];
  assign buf_rd         = strb_q[1];
  assign buf_rst        = strb_q[0];
  assign seq_busy       = busy_q;
  assign seq_done       = done_q;
  assign underrun       = underrun_q;
  assign overflow       = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_decod_seq.sv
`default_nettype none
// ============================================================================
// tb_cmd_decod_seq : scoreboard bench for the command playback decoder
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cmd_decod_seq;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_ODT  = 7'b1000000;
  localparam logic [6:0] F_CKE  = 7'b0100000;
  localparam logic [6:0] F_DQ   = 7'b0001000;
  localparam logic [6:0] F_DCI  = 7'b0000001;

  logic        clk = 1'b0;
  logic        mrst_n = 1'b0;
  logic [31:0] enc_cmd = 32'h0;
  logic        enc_wr = 1'b0;
  logic        enc_done = 1'b0;
  logic        clr_err = 1'b0;
  logic [14:0] phy_addr;
  logic [2:0]  phy_bank, phy_rcw;
  logic        phy_odt_en, phy_cke, phy_sel, phy_dq_en, phy_dqs_en, phy_dqs_toggle, phy_dci;
  logic        buf_wr, buf_rd, buf_rst, seq_busy, seq_done, underrun, overflow;

  cmd_decod_seq dut (
    .clk(clk), .mrst_n(mrst_n), .enc_cmd(enc_cmd), .enc_wr(enc_wr), .enc_done(enc_done),
    .clr_err(clr_err), .phy_addr(phy_addr), .phy_bank(phy_bank), .phy_rcw(phy_rcw),
    .phy_odt_en(phy_odt_en), .phy_cke(phy_cke), .phy_sel(phy_sel), .phy_dq_en(phy_dq_en),
    .phy_dqs_en(phy_dqs_en), .phy_dqs_toggle(phy_dqs_toggle), .phy_dci(phy_dci),
    .buf_wr(buf_wr), .buf_rd(buf_rd), .buf_rst(buf_rst), .seq_busy(seq_busy),
    .seq_done(seq_done), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  bank;
    logic [2:0]  rcw;
    logic [6:0]  flags;
    logic [2:0]  strb;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   done_pend = 1'b0;

  function automatic logic [31:0] mk(logic [14:0] a, logic [2:0] b, logic [2:0] rcw,
                                     logic [6:0] f, logic bw, logic br, logic nop, logic brst);
    return {a, b, rcw, f, bw, br, nop, brst};
  endfunction

  function automatic logic [31:0] pz(int skip, logic done, logic [2:0] b, logic [6:0] f, logic nop);
    logic [14:0] a;
    a = 15'(skip);
    a[10] = done;
    return mk(a, b, 3'b000, f, 1'b0, 1'b0, nop, 1'b0);
  endfunction

  // Expand one word into its expected per-cycle output images.
  task automatic push_word(input logic [31:0] w);
    exp_t e;
    int   ext;
    bit   is_done;
    is_done = (w[13:11] == 3'b000) && w[27];
    ext     = (w[13:11] == 3'b000) ? int'(w[26:17]) : int'(w[1]);
    e.addr  = w[31:17];
    e.bank  = w[16:14];
    e.rcw   = w[13:11];
    e.flags = w[10:4];
    e.strb  = {w[3], w[2], w[0]};
    e.last  = is_done && (ext == 0);
    sb.push_back(e);
    for (int i = 0; i < ext; i++) begin
      e.rcw  = 3'b000;
      e.strb = 3'b000;
      e.last = is_done && (i == ext - 1);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] w, input bit push);
    enc_cmd = w;
    enc_wr  = 1'b1;
    if (push) push_word(w);
    tick();
    enc_wr  = 1'b0;
  endtask

  task automatic sb_monitor();
    exp_t        e;
    logic [30:0] act;
    forever begin
      @(negedge clk);
      act = {phy_addr, phy_bank, phy_rcw, phy_odt_en, phy_cke, phy_sel, phy_dq_en,
             phy_dqs_en, phy_dqs_toggle, phy_dci, buf_wr, buf_rd, buf_rst};
      if (!mon_en) begin
        done_pend = 1'b0;
      end else if (seq_busy) begin
        n_checks++;
        if (done_pend) begin
          n_fail++;
          $display("FAIL sb_seq_done: got busy=1 done=%0b required busy=0 done=1 at %0t", seq_done, $time);
        end
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_busy: got outputs %h with no word expected at %0t", act, $time);
          done_pend = 1'b0;
        end else begin
          e = sb.pop_front();
          if (act !== {e.addr, e.bank, e.rcw, e.flags, e.strb} || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_cycle: got %h done=%0b required %h done=0 at %0t",
                     act, seq_done, {e.addr, e.bank, e.rcw, e.flags, e.strb}, $time);
          end
          done_pend = e.last;
        end
      end else begin
        n_checks++;
        if (seq_done !== done_pend || act !== 31'h0) begin
          n_fail++;
          $display("FAIL sb_idle: got outputs %h done=%0b required 0 done=%0b at %0t",
                   act, seq_done, done_pend, $time);
        end
        done_pend = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      tick();
      if (!seq_busy && !seq_done && sb.size() == 0) ok = 1'b1;
    end
    tick();
    tick();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_idle: got busy after %0d cycles, required idle (queue=%0d)", max_cycles, sb.size());
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    mrst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({phy_addr, phy_bank, phy_rcw, buf_wr, buf_rd, buf_rst} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {phy_addr, phy_bank, phy_rcw, buf_wr, buf_rd, buf_rst});
    end
    n_checks++;
    if ({seq_busy, seq_done, underrun, overflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 0000", {seq_busy, seq_done, underrun, overflow});
    end
    mrst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_pause_done();
    int busy_cnt = 0, first = -1, done_at = -1, done_cnt = 0, rcw_bad = 0;
    wr(pz(5, 1'b1, 3'd0, F_NONE, 1'b0), 1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (seq_busy) begin
        busy_cnt++;
        if (first < 0) first = i;
        if (phy_rcw !== 3'b000) rcw_bad++;
      end
      if (seq_done) begin
        done_cnt++;
        done_at = i;
      end
    end
    n_checks++;
    if (first !== 1) begin
      n_fail++;
      $display("FAIL pause_latency: got first busy at %0d required 1", first);
    end
    n_checks++;
    if (busy_cnt !== 6 || rcw_bad !== 0) begin
      n_fail++;
      $display("FAIL pause_cycles: got busy=%0d rcw_bad=%0d required 6 and 0", busy_cnt, rcw_bad);
    end
    n_checks++;
    if (done_cnt !== 1 || done_at !== first + 6) begin
      n_fail++;
      $display("FAIL pause_done_pulse: got %0d pulses at %0d required 1 at %0d", done_cnt, done_at, first + 6);
    end
  endtask

  task automatic test_nop_cmd();
    wr(mk(15'h0ABC, 3'd5, 3'b011, F_ODT | F_DCI, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    wr(pz(0, 1'b1, 3'd5, F_NONE, 1'b0), 1'b1);
    tick();
    n_checks++;
    if (phy_rcw !== 3'b011 || buf_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL nop_first_cycle: got rcw=%b buf_rst=%b required 011 1", phy_rcw, buf_rst);
    end
    tick();
    n_checks++;
    if (phy_rcw !== 3'b000 || buf_rst !== 1'b0 || phy_odt_en !== 1'b1 || phy_dci !== 1'b1 ||
        phy_addr !== 15'h0ABC) begin
      n_fail++;
      $display("FAIL nop_second_cycle: got rcw=%b rst=%b odt=%b dci=%b addr=%h required 000 0 1 1 0abc",
               phy_rcw, buf_rst, phy_odt_en, phy_dci, phy_addr);
    end
    wait_idle(20);
  endtask

  task automatic test_back_to_back();
    int cnt = 0, first = -1, last = -1;
    fork
      begin
        for (int k = 0; k < 4; k++)
          wr(mk(15'(16'h0100 + k), 3'(k), 3'(k + 1), 7'(k * 9), 1'(k), 1'(k >> 1), 1'b0, 1'(k == 3)), 1'b1);
        wr(pz(0, 1'b1, 3'd0, F_NONE, 1'b0), 1'b1);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          tick();
          if (seq_busy) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
          end
        end
      end
    join
    n_checks++;
    if (cnt !== 5 || last - first + 1 !== 5) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d busy cycles over span %0d required 5 and 5", cnt, last - first + 1);
    end
    wait_idle(20);
  endtask

  task automatic test_linear_read();
    int cnt = 0, bw = 0, bw_bad = 0, dn = 0;
    fork
      begin
        wr(mk(15'h1234, 3'd3, 3'b100, F_CKE, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wr(pz(1, 1'b0, 3'd3, F_CKE, 1'b0), 1'b1);
        wr(mk(15'h0028, 3'd3, 3'b010, F_CKE | F_DQ, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        wr(mk(15'h0030, 3'd3, 3'b010, F_CKE | F_DQ, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        wr(mk(15'h0400, 3'd3, 3'b101, F_CKE, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wr(pz(2, 1'b1, 3'd3, F_CKE, 1'b1), 1'b1);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          tick();
          if (seq_busy) cnt++;
          if (buf_wr) bw++;
          if (buf_wr && phy_rcw !== 3'b010) bw_bad++;
          if (seq_done) dn++;
        end
      end
    join
    n_checks++;
    if (cnt !== 11) begin
      n_fail++;
      $display("FAIL linear_cycles: got %0d busy cycles required 11", cnt);
    end
    n_checks++;
    if (bw !== 2 || bw_bad !== 0 || dn !== 1) begin
      n_fail++;
      $display("FAIL linear_strobes: got buf_wr=%0d off_read=%0d done=%0d required 2 0 1", bw, bw_bad, dn);
    end
    wait_idle(20);
  endtask

  task automatic test_underrun();
    exp_t        e;
    logic [31:0] w2;
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_pre: got %b required 0", underrun);
    end
    w2 = mk(15'h0008, 3'd1, 3'b010, F_CKE | F_DQ | F_DCI, 1'b1, 1'b0, 1'b0, 1'b0);
    wr(mk(15'h0100, 3'd1, 3'b100, F_CKE | F_DCI, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    wr(w2, 1'b1);
    // Done word arrives on the 5th edge after w2: three starved fetches precede it.
    e = '{addr: w2[31:17], bank: w2[16:14], rcw: 3'b000, flags: w2[10:4], strb: 3'b000, last: 1'b0};
    repeat (3) sb.push_back(e);
    repeat (4) tick();
    wr(pz(0, 1'b1, 3'd1, F_NONE, 1'b0), 1'b1);
    wait_idle(20);
    n_checks++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_set: got %b required 1", underrun);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_clear: got %b required 0", underrun);
    end
  endtask

  task automatic test_overflow();
    bit started = 1'b0;
    wr(pz(1023, 1'b0, 3'd2, F_CKE, 1'b0), 1'b1);
    for (int i = 0; i < 10 && !started; i++) begin
      tick();
      if (seq_busy) started = 1'b1;
    end
    n_checks++;
    if (!started) begin
      n_fail++;
      $display("FAIL overflow_start: got busy=0 required 1 within 10 cycles");
    end
    for (int i = 0; i < 127; i++)
      wr(mk(15'(i + 1), 3'(i), 3'(1 + i % 7), 7'(i), 1'(i), 1'(i >> 1), 1'b0, 1'(i >> 2)), 1'b1);
    wr(pz(0, 1'b1, 3'd0, F_NONE, 1'b0), 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_at_128: got %b required 0", overflow);
    end
    wr(mk(15'h7FFF, 3'd7, 3'b111, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_at_129: got %b required 1", overflow);
    end
    clr_err = 1'b1;
    wr(mk(15'h7FFE, 3'd7, 3'b111, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1), 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_clear_vs_event: got %b required 1", overflow);
    end
    tick();
    clr_err = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b required 0", overflow);
    end
    wait_idle(3000);
  endtask

  task automatic test_reset_mid_hold();
    bit started = 1'b0;
    int activity = 0;
    mon_en = 1'b0;
    wr(pz(100, 1'b0, 3'd4, F_CKE | F_ODT, 1'b0), 1'b0);
    wr(mk(15'h0055, 3'd4, 3'b100, F_CKE, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    for (int i = 0; i < 10 && !started; i++) begin
      tick();
      if (seq_busy) started = 1'b1;
    end
    repeat (60) tick();
    mrst_n = 1'b0;
    tick();
    n_checks++;
    if ({phy_addr, phy_bank, phy_odt_en, phy_cke, seq_busy, seq_done} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got %h required 0 (started=%0b)",
               {phy_addr, phy_bank, phy_odt_en, phy_cke, seq_busy, seq_done}, started);
    end
    mrst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (seq_busy || seq_done || phy_rcw !== 3'b000) activity++;
    end
    n_checks++;
    if (activity !== 0) begin
      n_fail++;
      $display("FAIL reset_fifo_empty: got %0d active cycles after reset required 0", activity);
    end
    sb.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    fork
      sb_monitor();
    join_none
    test_reset();
    test_pause_done();
    test_nop_cmd();
    test_back_to_back();
    test_linear_read();
    test_underrun();
    test_overflow();
    test_reset_mid_hold();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
